// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I controller; the datapath muxes use
// the same alu_op/pc_src/mem_to_reg/alu_src values as the single-cycle decoder.
package rv32i_ctrl_pkg;

  localparam logic [6:0] OPC_R      = 7'd51;
  localparam logic [6:0] OPC_I      = 7'd19;
  localparam logic [6:0] OPC_LOAD   = 7'd3;
  localparam logic [6:0] OPC_STORE  = 7'd35;
  localparam logic [6:0] OPC_BRANCH = 7'd99;
  localparam logic [6:0] OPC_JAL    = 7'd111;
  localparam logic [6:0] OPC_JALR   = 7'd103;
  localparam logic [6:0] OPC_LUI    = 7'd55;
  localparam logic [6:0] OPC_AUIPC  = 7'd23;

  // state | meaning: BOOT post-reset idle, FETCH IR read, DECODE opcode check,
  // EXEC ALU/branch, MEM data access, WB register write, TRAP halted until reset
  localparam logic [2:0] ST_BOOT   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_TRAP   = 3'd6;

  localparam logic [1:0] ALU_SRC_RS2  = 2'b00;
  localparam logic [1:0] ALU_SRC_IIMM = 2'b01;
  localparam logic [1:0] ALU_SRC_SIMM = 2'b10;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_ITYPE  = 2'b10;
  localparam logic [1:0] ALU_OP_RTYPE  = 2'b11;

  localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JAL    = 2'b10;
  localparam logic [1:0] PC_SRC_JALR   = 2'b11;

  localparam logic [2:0] M2R_ALU    = 3'b000;
  localparam logic [2:0] M2R_MEM    = 3'b001;
  localparam logic [2:0] M2R_PC4    = 3'b010;
  localparam logic [2:0] M2R_UIMM   = 3'b011;
  localparam logic [2:0] M2R_PCUIMM = 3'b100;

  typedef struct packed {
    logic [1:0] alu_src;
    logic [1:0] alu_op;
  } alu_ctrl_t;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    case (op)
      OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_BRANCH,
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

  function automatic alu_ctrl_t alu_ctrl(input logic [6:0] op);
    alu_ctrl_t c;
    c = '{alu_src: ALU_SRC_RS2, alu_op: ALU_OP_ADD};
    case (op)
      OPC_R:      c = '{alu_src: ALU_SRC_RS2,  alu_op: ALU_OP_RTYPE};
      OPC_I:      c = '{alu_src: ALU_SRC_IIMM, alu_op: ALU_OP_ITYPE};
      OPC_LOAD:   c = '{alu_src: ALU_SRC_IIMM, alu_op: ALU_OP_ADD};
      OPC_STORE:  c = '{alu_src: ALU_SRC_SIMM, alu_op: ALU_OP_ADD};
      OPC_BRANCH: c = '{alu_src: ALU_SRC_RS2,  alu_op: ALU_OP_BRANCH};
      OPC_JALR:   c = '{alu_src: ALU_SRC_IIMM, alu_op: ALU_OP_ADD};
      default:    c = '{alu_src: ALU_SRC_RS2,  alu_op: ALU_OP_ADD};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// Memory wait counter: expired marks the last permitted wait cycle in FETCH/MEM.
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I sequencer: steps one instruction through FETCH..WB and drives
// the shared memory handshake plus datapath write enables.
module multicycle_control_fsm
  import rv32i_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_write,
  output logic       alu_out_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic [2:0] mem_to_reg,
  output logic       illegal_instr,
  output logic       bus_error,
  output logic [2:0] state_dbg
);

  logic [2:0] state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       bus_err_q, bus_err_d;
  logic       wait_expired;
  logic       is_store, is_mem_op;
  alu_ctrl_t  alu_c;

  assign alu_c     = alu_ctrl(opcode);
  assign is_store  = (opcode == OPC_STORE);
  assign is_mem_op = (opcode == OPC_LOAD) || is_store;

  // Any state change restarts the count, so each FETCH/MEM visit starts from zero.
  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (state_d != state_q),
    .en_i     (((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready),
    .expired_o(wait_expired)
  );

  always_comb begin
    state_d       = state_q;
    illegal_d     = illegal_q;
    bus_err_d     = bus_err_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr_sel  = 1'b0;
    ir_write      = 1'b0;
    alu_out_write = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src       = ALU_SRC_RS2;
    alu_op        = ALU_OP_ADD;
    pc_src        = PC_SRC_PLUS4;
    mem_to_reg    = M2R_ALU;
    case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = ST_DECODE;
        end else if (wait_expired) begin
          bus_err_d = 1'b1;
          state_d   = ST_TRAP;
        end
      end
      ST_DECODE: begin
        if (is_legal_opcode(opcode)) begin
          state_d = ST_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = ST_TRAP;
        end
      end
      ST_EXEC: begin
        alu_out_write = 1'b1;
        alu_src       = alu_c.alu_src;
        alu_op        = alu_c.alu_op;
        if (is_mem_op) begin
          state_d = ST_MEM;
        end else if (opcode == OPC_BRANCH) begin
          pc_write = 1'b1;
          pc_src   = branch_taken ? PC_SRC_BRANCH : PC_SRC_PLUS4;
          state_d  = ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_store;
        if (mem_ready) begin
          pc_write = is_store;
          state_d  = is_store ? ST_FETCH : ST_WB;
        end else if (wait_expired) begin
          bus_err_d = 1'b1;
          state_d   = ST_TRAP;
        end
      end
      ST_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        state_d   = ST_FETCH;
        case (opcode)
          OPC_LOAD:  mem_to_reg = M2R_MEM;
          OPC_JAL:   begin mem_to_reg = M2R_PC4; pc_src = PC_SRC_JAL;  end
          OPC_JALR:  begin mem_to_reg = M2R_PC4; pc_src = PC_SRC_JALR; end
          OPC_LUI:   mem_to_reg = M2R_UIMM;
          OPC_AUIPC: mem_to_reg = M2R_PCUIMM;
          default:   mem_to_reg = M2R_ALU;
        endcase
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_BOOT;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign illegal_instr = illegal_q;
  assign bus_error     = bus_err_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: builds an expected per-cycle trace for each
// instruction from its class and memory wait counts, then replays it on the DUT.
module tb_multicycle_control_fsm;

  localparam int TO = 4;
  localparam logic [20:0] MASK_ALL = 21'h1FFFFF;
  localparam logic [20:0] MASK_NOALU = 21'h1FF87F;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       mem_ready = 1'b0;
  logic       branch_taken = 1'b0;
  logic       mem_req, mem_we, mem_addr_sel, ir_write, alu_out_write;
  logic       pc_write, reg_write, illegal_instr, bus_error;
  logic [1:0] alu_src, alu_op, pc_src;
  logic [2:0] mem_to_reg, state_dbg;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_write(ir_write), .alu_out_write(alu_out_write),
    .pc_write(pc_write), .reg_write(reg_write), .alu_src(alu_src), .alu_op(alu_op),
    .pc_src(pc_src), .mem_to_reg(mem_to_reg), .illegal_instr(illegal_instr),
    .bus_error(bus_error), .state_dbg(state_dbg)
  );

  wire [20:0] obs = {state_dbg, mem_req, mem_we, mem_addr_sel, ir_write, alu_out_write,
                     pc_write, reg_write, alu_src, alu_op, pc_src, mem_to_reg,
                     illegal_instr, bus_error};

  typedef struct packed {
    logic        rdy;
    logic        tkn;
    logic [6:0]  opc;
    logic        dc_alu;
    logic [20:0] exp;
  } step_t;

  step_t      q[$];
  int         total = 0;
  int         bad = 0;
  logic       ill_m = 1'b0;
  logic       be_m = 1'b0;
  logic [6:0] legal_ops [0:8] = '{7'd51, 7'd19, 7'd3, 7'd35, 7'd99, 7'd111, 7'd103, 7'd55, 7'd23};

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rnd7();
    return 7'($urandom);
  endfunction

  function automatic logic [20:0] mk(input logic [2:0] st, input logic req, we, asel, irw,
                                     aow, pcw, rw, input logic [1:0] asrc, aop, psrc,
                                     input logic [2:0] m2r);
    return {st, req, we, asel, irw, aow, pcw, rw, asrc, aop, psrc, m2r, ill_m, be_m};
  endfunction

  function automatic logic [20:0] idle(input logic [2:0] st);
    return mk(st, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0);
  endfunction

  task automatic push(input logic rdy, tkn, input logic [6:0] opc, input logic dc,
                      input logic [20:0] e);
    q.push_back({rdy, tkn, opc, dc, e});
  endtask

  task automatic push_trap(input int n);
    for (int i = 0; i < n; i++) push(rnd(), rnd(), rnd7(), 1'b0, idle(3'd6));
  endtask

  task automatic gen_boot();
    push(rnd(), rnd(), rnd7(), 1'b0, idle(3'd0));
  endtask

  // One instruction: fw/mw are wait cycles before ready in FETCH/MEM; >= TO times out.
  task automatic gen_instr(input logic [6:0] op, input int fw, input int mw, input logic tkn);
    logic [1:0] asrc, aop, psrc;
    logic [2:0] m2r;
    logic       dc, st, legal;
    for (int i = 0; i < fw && i < TO; i++)
      push(1'b0, rnd(), rnd7(), 1'b0,
           mk(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0));
    if (fw >= TO) begin
      be_m = 1'b1;
      push_trap(3);
      return;
    end
    push(1'b1, rnd(), rnd7(), 1'b0,
         mk(3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0));
    legal = 1'b0;
    foreach (legal_ops[k]) if (legal_ops[k] == op) legal = 1'b1;
    push(rnd(), rnd(), op, 1'b0, idle(3'd2));
    if (!legal) begin
      ill_m = 1'b1;
      push_trap(6);
      return;
    end
    dc = 1'b0;
    case (op)
      7'd51:   begin asrc = 2'd0; aop = 2'd3; end
      7'd19:   begin asrc = 2'd1; aop = 2'd2; end
      7'd3:    begin asrc = 2'd1; aop = 2'd0; end
      7'd35:   begin asrc = 2'd2; aop = 2'd0; end
      7'd99:   begin asrc = 2'd0; aop = 2'd1; end
      default: begin asrc = 2'd0; aop = 2'd0; dc = 1'b1; end
    endcase
    if (op == 7'd99) begin
      push(rnd(), tkn, op, dc, mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                                  asrc, aop, tkn ? 2'd1 : 2'd0, 3'd0));
      return;
    end
    push(rnd(), rnd(), op, dc, mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                  asrc, aop, 2'd0, 3'd0));
    if (op == 7'd3 || op == 7'd35) begin
      st = (op == 7'd35);
      for (int i = 0; i < mw && i < TO; i++)
        push(1'b0, rnd(), op, 1'b0,
             mk(3'd4, 1'b1, st, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0));
      if (mw >= TO) begin
        be_m = 1'b1;
        push_trap(3);
        return;
      end
      push(1'b1, rnd(), op, 1'b0,
           mk(3'd4, 1'b1, st, 1'b1, 1'b0, 1'b0, st, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0));
      if (st) return;
    end
    case (op)
      7'd3:    begin m2r = 3'd1; psrc = 2'd0; end
      7'd111:  begin m2r = 3'd2; psrc = 2'd2; end
      7'd103:  begin m2r = 3'd2; psrc = 2'd3; end
      7'd55:   begin m2r = 3'd3; psrc = 2'd0; end
      7'd23:   begin m2r = 3'd4; psrc = 2'd0; end
      default: begin m2r = 3'd0; psrc = 2'd0; end
    endcase
    push(rnd(), rnd(), op, 1'b0, mk(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                                    2'd0, 2'd0, psrc, m2r));
  endtask

  // Entered #1 after a posedge (or mid-cycle); leaves #1 after a posedge.
  task automatic run_trace(input string name);
    logic [20:0] m;
    foreach (q[i]) begin
      mem_ready    = q[i].rdy;
      branch_taken = q[i].tkn;
      opcode       = q[i].opc;
      @(negedge clk);
      m = q[i].dc_alu ? MASK_NOALU : MASK_ALL;
      total++;
      if ((obs & m) !== (q[i].exp & m)) begin
        bad++;
        $display("FAIL %s step %0d: got %h want %h", name, i, obs, q[i].exp);
      end
      @(posedge clk);
      #1;
    end
    q.delete();
  endtask

  task automatic do_reset(input int hold);
    #2;
    rst_n = 1'b0;
    ill_m = 1'b0;
    be_m  = 1'b0;
    for (int i = 0; i < hold; i++) begin
      mem_ready = rnd(); branch_taken = rnd(); opcode = rnd7();
      @(negedge clk);
      total++;
      if (obs !== 21'd0) begin
        bad++;
        $display("FAIL reset_hold: got %h want 0", obs);
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(3);
  endtask

  task automatic test_r_type();
    do_reset(1);
    gen_boot();
    gen_instr(7'd51, 0, 0, 1'b0);
    gen_instr(7'd19, 0, 0, 1'b0);
    run_trace("r_type");
  endtask

  task automatic test_load_wait();
    do_reset(1);
    gen_boot();
    gen_instr(7'd3, 0, 3, 1'b0);
    gen_instr(7'd35, 1, 0, 1'b0);
    gen_instr(7'd3, 0, 0, 1'b0);
    run_trace("load_wait");
  endtask

  task automatic test_branch();
    do_reset(1);
    gen_boot();
    gen_instr(7'd99, 0, 0, 1'b1);
    gen_instr(7'd99, 2, 0, 1'b0);
    gen_instr(7'd111, 0, 0, 1'b0);
    gen_instr(7'd103, 0, 0, 1'b0);
    run_trace("branch_jump");
  endtask

  task automatic test_illegal();
    do_reset(1);
    gen_boot();
    gen_instr(7'h7F, 0, 0, 1'b0);
    run_trace("illegal_trap");
    do_reset(1);
    gen_boot();
    gen_instr(7'd55, 0, 0, 1'b0);
    gen_instr(7'd23, 0, 0, 1'b0);
    run_trace("after_illegal");
  endtask

  task automatic test_timeout();
    do_reset(1);
    gen_boot();
    gen_instr(7'd51, TO, 0, 1'b0);
    run_trace("fetch_timeout");
    do_reset(1);
    gen_boot();
    gen_instr(7'd51, TO - 1, 0, 1'b0);
    gen_instr(7'd3, 0, TO - 1, 1'b0);
    gen_instr(7'd35, 0, TO, 1'b0);
    run_trace("mem_timeout");
  endtask

  task automatic test_reset_mid_store();
    do_reset(1);
    gen_boot();
    gen_instr(7'd35, 0, 3, 1'b0);
    void'(q.pop_back());
    void'(q.pop_back());
    run_trace("store_pre_reset");
    mem_ready = 1'b1;
    opcode    = 7'd35;
    #2;
    rst_n = 1'b0;
    ill_m = 1'b0;
    be_m  = 1'b0;
    #1;
    total++;
    if (obs !== 21'd0) begin
      bad++;
      $display("FAIL async_reset: got %h want 0", obs);
    end
    @(negedge clk);
    total++;
    if (obs !== 21'd0) begin
      bad++;
      $display("FAIL reset_held_store: got %h want 0", obs);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    gen_boot();
    gen_instr(7'd51, 0, 0, 1'b0);
    run_trace("after_mid_reset");
  endtask

  task automatic test_random();
    do_reset(1);
    gen_boot();
    for (int n = 0; n < 40; n++)
      gen_instr(legal_ops[$urandom_range(0, 8)], $urandom_range(0, TO - 1),
                $urandom_range(0, TO - 1), rnd());
    gen_instr(7'd0, 0, 0, 1'b0);
    run_trace("random");
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_load_wait();
    test_branch();
    test_illegal();
    test_timeout();
    test_reset_mid_store();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
